// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared constants, FSM state type and slice-count helper for cla_seq_adder.
package cla_seq_pkg;

    localparam int CHUNK_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int num_chunks(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// cla_seq_adder_if: operand/result valid-ready bundle; sub exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_adder_if #(
    parameter int WIDTH = 20
);
    logic             in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
    modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout);
    modport slave  (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/carry_lookahead_adder_5bit_modular.sv
// carry_lookahead_adder_5bit_modular: 5-bit adder with every carry expanded from generate/propagate terms.
module carry_lookahead_adder_5bit_modular (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Cin,
    output logic [4:0] Sum,
    output logic       Cout
);
    logic [4:0] p, g;
    logic [5:0] c;
    logic       pp, cc;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        c = '0;
        pp = 1'b1;
        cc = 1'b0;
        c[0] = Cin;
        for (int i = 1; i <= 5; i++) begin
            pp = 1'b1;
            cc = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i] = cc | (pp & Cin);
        end
    end

    assign Sum  = p ^ c[4:0];
    assign Cout = c[5];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit add fed LSB-first through one 5-bit CLA, one slice per cycle.
// Define CLA_SEQ_SUB_EN to add the sub port (a + ~b + 1).
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input logic            clk,
    input logic            rst_n,
    cla_seq_adder_if.slave io
);
    localparam int CHUNKS = num_chunks(WIDTH);
    localparam int IDX_W = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [CHUNK_W-1:0] cla_b, cla_sum;
    logic               cla_cout;
`ifdef CLA_SEQ_SUB_EN
    logic               sub_q, sub_d;

    assign cla_b = sub_q ? ~b_q[CHUNK_W-1:0] : b_q[CHUNK_W-1:0];
`else
    assign cla_b = b_q[CHUNK_W-1:0];
`endif

    carry_lookahead_adder_5bit_modular u_cla (
        .A    (a_q[CHUNK_W-1:0]),
        .B    (cla_b),
        .Cin  (carry_q),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d    = sub_q;
`endif
        if (state_q == IDLE && io.in_valid) begin
            state_d  = RUN;
            a_d      = io.a;
            b_d      = io.b;
            result_d = '0;
            idx_d    = '0;
`ifdef CLA_SEQ_SUB_EN
            sub_d    = io.sub;
            carry_d  = io.sub | io.cin;
`else
            carry_d  = io.cin;
`endif
        end else if (state_q == RUN) begin
            result_d[idx_q*CHUNK_W +: CHUNK_W] = cla_sum;
            carry_d = cla_cout;
            a_d     = a_q >> CHUNK_W;
            b_d     = b_q >> CHUNK_W;
            idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
            state_d = idx_q == LAST ? DONE : RUN;
        end else if (state_q == DONE && io.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign io.in_ready  = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.sum       = result_q;
    assign io.cout      = carry_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: random and directed stimulus, expected results queued at acceptance and
// compared by an independent monitor on every output handshake.
module tb_cla_seq_adder;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_seq_adder_if #(.WIDTH(W)) io ();
    cla_seq_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int unsigned av = a;
        int unsigned bv = sub ? (2**W - 1) - b : b;
        int unsigned cv = sub ? 1 : cin;
        return (W+1)'((av + bv + cv) % (2**(W+1)));
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n = 0;
        @(negedge clk);
        io.a = a;
        io.b = b;
        io.cin = cin;
`ifdef CLA_SEQ_SUB_EN
        io.sub = sub;
`endif
        io.in_valid = 1'b1;
        while (!io.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            check("accept_timeout", 32'(io.in_ready), 1);
            io.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(a, b, cin, sub));
        #1 io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(io.out_valid), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'({io.cout, io.sum}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic rc, rs;
        logic [W:0] e1;
        int n;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.cin = 1'b0;
        io.out_ready = 1'b1;
`ifdef CLA_SEQ_SUB_EN
        io.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(io.in_ready), 1);
        check("rst_out_valid", 32'(io.out_valid), 0);
        check("rst_sum", 32'(io.sum), 0);
        check("rst_cout", 32'(io.cout), 0);
        rst_n = 1'b1;

        send(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("latency_out_valid", 32'(io.out_valid), 32'(k == 4));
        end
        drain();

        send(20'h03039, 20'h0D431, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            rc = 1'($urandom());
            rs = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom());
`endif
            send(ra, rb, rc, rs);
        end
        drain();

        io.out_ready = 1'b0;
        ra = W'($urandom());
        rb = W'($urandom());
        e1 = model(ra, rb, 1'b1, 1'b0);
        send(ra, rb, 1'b1, 1'b0);
        n = 0;
        while (!io.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 32'(io.out_valid), 1);
        ra = W'($urandom());
        rb = W'($urandom());
        io.a = ra;
        io.b = rb;
        io.cin = 1'b0;
        io.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_result", 32'({io.cout, io.sum}), 32'(e1));
            check("bp_in_ready", 32'(io.in_ready), 0);
            check("bp_out_valid", 32'(io.out_valid), 1);
        end
        @(posedge clk);
        #1 io.out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_in_ready", 32'(io.in_ready), 0);
        send(ra, rb, 1'b0, 1'b0);
        drain();

        send(W'($urandom()), W'($urandom()), 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", 32'(io.in_ready), 1);
        check("midrst_out_valid", 32'(io.out_valid), 0);
        check("midrst_sum", 32'(io.sum), 0);
        exp_q.delete();
        rst_n = 1'b1;
        send(20'd1, 20'd1, 1'b0, 1'b0);
        drain();

`ifdef CLA_SEQ_SUB_EN
        send(20'd100, 20'd1, 1'b0, 1'b1);
        send(20'd0, 20'd1, 1'b1, 1'b1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-word sequential adder that sits directly upstream of the team's 5-bit carry-lookahead adder (`carry_lookahead_adder_5bit_modular`). It feeds that adder and consumes its outputs. Each operation accepts a WIDTH-bit operand pair over a valid/ready handshake. It feeds one 5-bit slice per cycle, LSB slice first, to a single CLA instance and chains the CLA's Cout into the next slice's Cin. It assembles the WIDTH-bit Sum and final carry, then presents them on a valid/ready output.

## Interface
- WIDTH, 20, operand/result width; must be a positive multiple of 5.
- CHUNKS, WIDTH/5, derived localparam; slices per operation.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into slice 0.
- sub  in  1  subtract select; present only with CLA_SEQ_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the top slice.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin (and sub) into shift registers; clear slice index idx and the result register; carry register ← cin; go to RUN.
- **RUN**
  - CLA inputs are the low 5 bits of the A/B shift registers and the carry register.
  - Each edge: the CLA's Sum is written to result slice idx; carry register ← CLA Cout; A/B shift right by 5; idx++.
  - When idx==CHUNKS-1, this edge goes to DONE.
  - in_ready=0; in_valid is ignored.
- **DONE**
  - out_valid=1; sum=result register; cout=carry register.
  - sum and cout are held stable while out_ready=0.
  - On out_ready, go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). This must match a WIDTH-bit behavioural add bit-exactly.
- idx width: clog2(CHUNKS), minimum 1 bit. idx never exceeds CHUNKS-1, so there is no wrap.
- Boundary cases:
  - WIDTH=5 (CHUNKS=1): RUN lasts one cycle.
  - A new input arriving in DONE is not accepted; in_ready stays 0 until the cycle after the output handshake.
- Reset, including mid-RUN or mid-DONE: state ← IDLE; any in-flight operation is dropped with no output.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, idx=0, state IDLE.
- Input accepted at edge T0. out_valid rises after edge T0+CHUNKS. For WIDTH=20 that is 4 edges after acceptance.
- Output handshake at edge Td; in_ready=1 in the following cycle.
- Minimum issue interval: CHUNKS+2 cycles (accept, CHUNKS RUN cycles, DONE, IDLE).
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- The CLA path is combinational within one cycle; register-to-register depth is one 5-bit CLA.

## Configuration
- Macro: `CLA_SEQ_SUB_EN`.
- Defined:
  - The `sub` port exists and is latched with the operands.
  - When sub=1, every B slice is inverted before the CLA and the initial carry is forced to 1; cin is ignored.
  - Result: {cout,sum} = a + ~b + 1, where cout=1 means no borrow.
  - When sub=0, behaviour is identical to add.
- Undefined: the port is absent; add only.

## Structure
- Package `cla_seq_pkg` holds:
  - localparam CHUNK_W=5;
  - the state enum type (IDLE, RUN, DONE);
  - a function computing CHUNKS from WIDTH.
- One sub-module: a single instance of the existing `carry_lookahead_adder_5bit_modular`, unmodified.
- No other hierarchy.

## Test plan
All scenarios use WIDTH=20.
- Reset: hold rst_n=0 for 2 edges -> in_ready=1, out_valid=0, sum=0x00000, cout=0.
- Carry ripple across slices: a=0xFFFFF, b=0x00001, cin=0 -> sum=0x00000, cout=1, with out_valid high exactly 4 edges after acceptance.
- Mixed add with carry-in: a=0x03039 (12345), b=0x0D431 (54321), cin=1 -> sum=0x1046B (66667), cout=0. Then run 1000 random vectors against a behavioural add.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands applied -> sum and cout are stable, in_ready=0, and the new operands are not accepted until after the output handshake.
- Mid-operation reset: assert rst_n=0 at the 2nd RUN cycle -> next cycle state is IDLE, out_valid=0, sum=0. A following op a=1, b=1 yields sum=0x00002.
- With `CLA_SEQ_SUB_EN`:
  - a=100, b=1, sub=1 -> sum=99, cout=1.
  - a=0, b=1, sub=1 -> sum=0xFFFFF, cout=0.
